// File: rtl/fp_booth_mul_seq_if.sv
// rtl/fp_booth_mul_seq_if.sv - operand/result handshake bundle for fp_booth_mul_seq
interface fp_booth_mul_seq_if #(
    parameter int W = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_product;
    logic [1:0]   out_exc;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_product, out_exc
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_product, out_exc
    );
endinterface

// File: rtl/fp_booth_mul_seq.sv
// rtl/fp_booth_mul_seq.sv - sequential FP multiplier, radix-4 Booth mantissa engine, one step per clock
module fp_booth_mul_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_booth_mul_seq_if.slave bus
);
    localparam int W    = EXP_W + MAN_W + 1;
    localparam int ITER = (MAN_W + 3) / 2;
    localparam int QW   = 2 * ITER;
    localparam int AW   = MAN_W + 4;
    localparam int EW   = EXP_W + 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_MIN = EW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_SPECIAL,
        S_NORM,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [W-1:0]          r_out_product;
    logic [1:0]            r_out_exc;
    logic [W-1:0]          r_res_product;
    logic [1:0]            r_res_exc;
    logic                  r_sign;
    logic signed [EW-1:0]  r_exp_sum;
    logic signed [AW-1:0]  r_mcand;
    logic signed [AW-1:0]  r_acc;
    logic [QW-1:0]         r_q;
    logic                  r_qm1;
    logic [CW-1:0]         r_cnt;

    logic [EXP_W-1:0]      w_a_exp, w_b_exp;
    logic [MAN_W-1:0]      w_a_man, w_b_man;
    logic                  w_invalid, w_zero;
    logic signed [EW-1:0]  w_exp_sum;
    logic [2:0]            w_sel;
    logic signed [AW-1:0]  w_addend, w_sum;
    logic [MAN_W+1:0]      w_prod_hi;
    logic                  w_shift;
    logic [MAN_W-1:0]      w_man;
    logic signed [EW-1:0]  w_exp_fin;
    logic                  w_ovf, w_unf;

    assign w_a_exp = bus.in_a[W-2:MAN_W];
    assign w_b_exp = bus.in_b[W-2:MAN_W];
    assign w_a_man = bus.in_a[MAN_W-1:0];
    assign w_b_man = bus.in_b[MAN_W-1:0];

    // Inf/NaN and denormals share the invalid code and take priority over zero.
    assign w_invalid = (&w_a_exp) | (&w_b_exp)
                     | ((w_a_exp == '0) && (w_a_man != '0))
                     | ((w_b_exp == '0) && (w_b_man != '0));
    assign w_zero    = (bus.in_a[W-2:0] == '0) | (bus.in_b[W-2:0] == '0);
    assign w_exp_sum = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - BIAS;

    assign w_sel = {r_q[1:0], r_qm1};

    always_comb begin
        w_addend = '0;
        case (w_sel)
            3'b001, 3'b010: w_addend = r_mcand;
            3'b011:         w_addend = r_mcand <<< 1;
            3'b100:         w_addend = -(r_mcand <<< 1);
            3'b101, 3'b110: w_addend = -r_mcand;
            default:        w_addend = '0;
        endcase
    end

    assign w_sum = r_acc + w_addend;

    // Significand product occupies the low 2*MAN_W+2 bits of {acc, q}; keep its top MAN_W+2.
    assign w_prod_hi = (MAN_W + 2)'({r_acc, r_q} >> MAN_W);
    assign w_shift   = w_prod_hi[MAN_W+1];
    assign w_man     = w_shift ? w_prod_hi[MAN_W:1] : w_prod_hi[MAN_W-1:0];
    assign w_exp_fin = r_exp_sum + $signed({{(EW-1){1'b0}}, w_shift});
    assign w_ovf     = (w_exp_fin >= EXP_MAX);
    assign w_unf     = (w_exp_fin < EXP_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
            r_out_exc     <= 2'b00;
            r_res_product <= '0;
            r_res_exc     <= 2'b00;
            r_sign        <= 1'b0;
            r_exp_sum     <= '0;
            r_mcand       <= '0;
            r_acc         <= '0;
            r_q           <= '0;
            r_qm1         <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_sign     <= bus.in_a[W-1] ^ bus.in_b[W-1];
                        r_exp_sum  <= w_exp_sum;
                        r_mcand    <= AW'({3'b001, w_a_man});
                        r_acc      <= '0;
                        r_q        <= QW'({2'b01, w_b_man});
                        r_qm1      <= 1'b0;
                        r_cnt      <= '0;
                        if (w_invalid || w_zero) begin
                            r_res_product <= '0;
                            r_res_exc     <= w_invalid ? 2'b11 : 2'b00;
                            r_state       <= S_SPECIAL;
                        end else begin
                            r_state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
                    r_q   <= {w_sum[1:0], r_q[QW-1:2]};
                    r_qm1 <= r_q[1];
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(ITER - 1)) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (w_ovf) begin
                        r_res_product <= '0;
                        r_res_exc     <= 2'b01;
                    end else if (w_unf) begin
                        r_res_product <= '0;
                        r_res_exc     <= 2'b10;
                    end else begin
                        r_res_product <= {r_sign, w_exp_fin[EXP_W-1:0], w_man};
                        r_res_exc     <= 2'b00;
                    end
                    r_state <= S_DONE;
                end
                S_SPECIAL: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer.
                    if (!r_out_valid) begin
                        r_out_valid   <= 1'b1;
                        r_out_product <= r_res_product;
                        r_out_exc     <= r_res_exc;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_product = r_out_product;
    assign bus.out_exc     = r_out_exc;
endmodule
